// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the BCD stopwatch.
//   state_t  - run-control FSM states
//   bcd_t    - one 4-bit BCD digit
//   BCD_MAX  - largest legal BCD digit value
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: single decade counter, 0..MAX, synchronous clear.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset (value -> 0)
//   clear      - synchronous zero, overrides en
//   en         - advance by one on this edge
//   next_value - value the digit will hold after the coming edge
//   carry      - en AND (value == MAX); enables the next digit up
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output bcd_t next_value,
    output logic carry
);

    bcd_t value;

    // ">=" rather than "==" so any out-of-range value falls back to 0.
    always_comb begin
        next_value = value;
        if (clear) begin
            next_value = '0;
        end else if (en) begin
            next_value = (value >= MAX) ? bcd_t'(0) : value + 4'd1;
        end
    end

    assign carry = en & (value == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: four-digit BCD stopwatch (tens-sec, sec, tenths, hundredths).
// Ports:
//   clk        - system clock, all state changes on rising edge
//   RESET      - asynchronous active-high reset
//   slow_clk   - unsynchronized ~100 Hz level; each rise yields one tick
//   start_stop - one-cycle pulse, toggles run/pause
//   clear      - one-cycle pulse, zeroes count and lap, returns to IDLE
//   lap        - one-cycle pulse, toggles display freeze while running
//   disp       - registered display {tens, sec, tenths, hundredths}
//   running    - high while in RUN
//   lap_active - high while the display is frozen
//   wrap       - one-cycle pulse on rollover MAX_TENS9.99 -> 00.00
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_TENS = 5
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        slow_clk,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    logic   sync1, sync2, prev;
    logic   tick;
    logic   count_en;
    state_t state;
    logic [15:0] lap_reg;
    logic [15:0] next_count;
    bcd_t   n0, n1, n2, n3;
    logic   c0, c1, c2, c3;

    // Two-flop synchronizer plus one history flop for rise detection.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= slow_clk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign tick     = sync2 & ~prev;
    // Registered state gates counting, so a tick alongside start_stop
    // counts when leaving RUN but not when entering it.
    assign count_en = tick & (state == RUN) & ~clear;

    bcd_digit #(.MAX(BCD_MAX)) u_hund (
        .clk(clk), .rst(RESET), .clear(clear), .en(count_en),
        .next_value(n0), .carry(c0)
    );
    bcd_digit #(.MAX(BCD_MAX)) u_tenth (
        .clk(clk), .rst(RESET), .clear(clear), .en(c0),
        .next_value(n1), .carry(c1)
    );
    bcd_digit #(.MAX(BCD_MAX)) u_sec (
        .clk(clk), .rst(RESET), .clear(clear), .en(c1),
        .next_value(n2), .carry(c2)
    );
    bcd_digit #(.MAX(bcd_t'(MAX_TENS))) u_tens (
        .clk(clk), .rst(RESET), .clear(clear), .en(c2),
        .next_value(n3), .carry(c3)
    );

    assign next_count = {n3, n2, n1, n0};

    // disp is loaded from the post-edge count so it changes on the same
    // edge as the digits rather than one cycle later.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            lap_reg    <= '0;
            disp       <= '0;
            wrap       <= 1'b0;
        end else begin
            wrap <= c3;
            if (clear) begin
                state      <= IDLE;
                running    <= 1'b0;
                lap_active <= 1'b0;
                lap_reg    <= '0;
                disp       <= '0;
            end else begin
                case (state)
                    IDLE: if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    PAUSE: if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase

                if ((state == RUN) && lap) begin
                    if (!lap_active) begin
                        lap_active <= 1'b1;
                        lap_reg    <= next_count;
                    end else begin
                        lap_active <= 1'b0;
                    end
                    disp <= next_count;
                end else begin
                    disp <= lap_active ? lap_reg : next_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        RESET;
    logic        slow_clk;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] disp, disp2;
    logic        running, running2;
    logic        lap_active, lap_active2;
    logic        wrap, wrap2;

    int errors = 0;
    int checks = 0;

    bcd_stopwatch u_dut (
        .clk(clk), .RESET(RESET), .slow_clk(slow_clk),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp(disp), .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    bcd_stopwatch #(.MAX_TENS(2)) u_dut2 (
        .clk(clk), .RESET(RESET), .slow_clk(slow_clk),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp(disp2), .running(running2), .lap_active(lap_active2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_fast();
        slow_clk = 1'b1;
        cyc(2);
        slow_clk = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick_fast();
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; slow_clk = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #22;
        check("reset_disp", disp, 16'h0000);
        check("reset_running", {15'd0, running}, 16'd0);
        check("reset_lap_active", {15'd0, lap_active}, 16'd0);
        check("reset_wrap", {15'd0, wrap}, 16'd0);
        @(posedge clk); #1;
        RESET = 1'b0;
        cyc(2);

        pulse_ss();
        check("start_running", {15'd0, running}, 16'd1);

        // Slow periods of 20 high + 20 low; count changes exactly 2 edges after first sample.
        for (int i = 0; i < 5; i++) begin
            slow_clk = 1'b1;
            cyc(2);
            check("tick_latency_before", disp, 16'(i));
            cyc(1);
            check("tick_latency_after", disp, 16'(i + 1));
            cyc(17);
            slow_clk = 1'b0;
            cyc(20);
        end
        check("five_ticks_disp", disp, 16'h0005);
        check("five_ticks_running", {15'd0, running}, 16'd1);

        ticks(118);
        check("at_0123", disp, 16'h0123);
        pulse_lap();
        check("lap_set", {15'd0, lap_active}, 16'd1);
        ticks(10);
        check("lap_frozen", disp, 16'h0123);
        pulse_lap();
        check("lap_release", {15'd0, lap_active}, 16'd0);
        check("lap_release_disp", disp, 16'h0133);

        ticks(2866);
        check("at_2999", disp, 16'h2999);
        check("dut2_at_2999", disp2, 16'h2999);
        slow_clk = 1'b1;
        cyc(3);
        check("dut2_wrap_disp", disp2, 16'h0000);
        check("dut2_wrap_pulse", {15'd0, wrap2}, 16'd1);
        check("carry_into_tens", disp, 16'h3000);
        check("no_wrap_at_3000", {15'd0, wrap}, 16'd0);
        cyc(1);
        check("dut2_wrap_one_cycle", {15'd0, wrap2}, 16'd0);
        check("dut2_running", {15'd0, running2}, 16'd1);
        slow_clk = 1'b0;
        cyc(2);

        ticks(2999);
        check("at_5999", disp, 16'h5999);
        slow_clk = 1'b1;
        cyc(2);
        check("pre_wrap_disp", disp, 16'h5999);
        check("pre_wrap_pulse", {15'd0, wrap}, 16'd0);
        cyc(1);
        check("wrap_disp", disp, 16'h0000);
        check("wrap_pulse", {15'd0, wrap}, 16'd1);
        check("wrap_running", {15'd0, running}, 16'd1);
        cyc(1);
        check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
        slow_clk = 1'b0;
        cyc(2);

        // Tick coinciding with start_stop in RUN is counted.
        slow_clk = 1'b1;
        cyc(2);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        check("ss_tick_run_disp", disp, 16'h0001);
        check("ss_tick_run_paused", {15'd0, running}, 16'd0);
        slow_clk = 1'b0;
        cyc(2);

        pulse_lap();
        check("lap_ignored_pause", {15'd0, lap_active}, 16'd0);

        // Tick coinciding with start_stop in PAUSE is not counted.
        slow_clk = 1'b1;
        cyc(2);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        check("ss_tick_pause_disp", disp, 16'h0001);
        check("ss_tick_pause_running", {15'd0, running}, 16'd1);
        slow_clk = 1'b0;
        cyc(2);

        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b0;
        check("clear_prio_disp", disp, 16'h0000);
        check("clear_prio_running", {15'd0, running}, 16'd0);
        tick_fast();
        check("idle_no_count", disp, 16'h0000);

        pulse_ss();
        ticks(7);
        pulse_lap();
        check("pre_reset_disp", disp, 16'h0007);
        check("pre_reset_lap", {15'd0, lap_active}, 16'd1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_disp", disp, 16'h0000);
        check("async_reset_running", {15'd0, running}, 16'd0);
        check("async_reset_lap", {15'd0, lap_active}, 16'd0);
        #1;
        RESET = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
